// File: rtl/traffic_pkg.sv
// Shared light codes, approach indices and controller state enum for traffic_signal.
// TRAFFIC_EMERGENCY_EN adds the emergency preemption state.
package traffic_pkg;

    localparam int unsigned LIGHT_W = 5;
    localparam int unsigned NUM_APP = 4;

    localparam logic [LIGHT_W-1:0] RED      = 5'b00001;
    localparam logic [LIGHT_W-1:0] YELLOW   = 5'b00010;
    localparam logic [LIGHT_W-1:0] GREEN    = 5'b00100;
    localparam int unsigned        WALK_BIT = 3;
    localparam int unsigned        EMG_BIT  = 4;
    localparam logic [LIGHT_W-1:0] EMG_CODE = GREEN | 5'b10000;

    localparam logic [1:0] F = 2'd0;
    localparam logic [1:0] R = 2'd1;
    localparam logic [1:0] B = 2'd2;
    localparam logic [1:0] L = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW
`ifdef TRAFFIC_EMERGENCY_EN
        , ST_EMG
`endif
    } state_t;

    // Lowest-index set bit of a 4-bit request vector (0 when none set).
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) lowest_set = 2'(i);
        end
    endfunction

endpackage

// File: rtl/traffic_density.sv
// Registered popcount of a camera frame: number of vehicle pixels in img_in.
module traffic_density #(
    parameter int unsigned IMG_W = 3072,
    parameter int unsigned D_W   = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IMG_W-1:0] img_in,
    output logic [D_W-1:0]   density
);

    logic [D_W-1:0] count_c;

    always_comb begin
        count_c = '0;
        for (int i = 0; i < IMG_W; i++) begin
            count_c = count_c + D_W'(img_in[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) density <= '0;
        else     density <= count_c;
    end

endmodule

// File: rtl/traffic_signal.sv
// Per-intersection light sequencer with frame density count, pedestrian walk and
// optional emergency preemption (enabled by defining TRAFFIC_EMERGENCY_EN).
module traffic_signal
    import traffic_pkg::*;
#(
    parameter int unsigned IMG_W      = 3072,
    parameter int unsigned D_W        = 14,
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IMG_W-1:0] img_in,
    input  logic             act,
    input  logic [3:0]       ped,
    input  logic [3:0]       emg,
    output logic [4:0]       out_f,
    output logic [4:0]       out_r,
    output logic [4:0]       out_b,
    output logic [4:0]       out_l,
    output logic [IMG_W-1:0] img_out,
    output logic [D_W-1:0]   density
);

    localparam int unsigned TMR_W = 16;

    state_t                            state, state_nx;
    logic [1:0]                        idx, idx_nx;
    logic [TMR_W-1:0]                  tmr, tmr_nx;
    logic [NUM_APP-1:0][LIGHT_W-1:0]   lights_c, lights_q;
    logic                              emg_any;
    logic [1:0]                        emg_j;
    logic                              in_emg;

`ifdef TRAFFIC_EMERGENCY_EN
    assign emg_any = |emg;
    assign emg_j   = lowest_set(emg);
`else
    logic unused_emg;
    assign unused_emg = ^emg;
    assign emg_any    = 1'b0;
    assign emg_j      = 2'd0;
`endif

    traffic_density #(
        .IMG_W (IMG_W),
        .D_W   (D_W)
    ) u_density (
        .clk     (clk),
        .rst     (rst),
        .img_in  (img_in),
        .density (density)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) img_out <= '0;
        else     img_out <= img_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= F;
            tmr      <= '0;
            lights_q <= {NUM_APP{RED}};
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            tmr      <= tmr_nx;
            lights_q <= lights_c;
        end
    end

    // Next state, then lights decoded from the next state so they register alongside it.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        tmr_nx   = tmr;
        lights_c = {NUM_APP{RED}};
        in_emg   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (emg_any) begin
`ifdef TRAFFIC_EMERGENCY_EN
                    state_nx = ST_EMG;
                    idx_nx   = emg_j;
                    tmr_nx   = '0;
`endif
                end else if (act) begin
                    state_nx = ST_GREEN;
                    idx_nx   = F;
                    tmr_nx   = TMR_W'(GREEN_CYC);
                end
            end
            ST_GREEN: begin
                if (emg_any) begin
`ifdef TRAFFIC_EMERGENCY_EN
                    if (emg_j == idx) begin
                        state_nx = ST_EMG;
                        tmr_nx   = '0;
                    end else begin
                        state_nx = ST_YELLOW;
                        tmr_nx   = TMR_W'(YELLOW_CYC);
                    end
`endif
                end else if (!act || tmr <= TMR_W'(1)) begin
                    state_nx = ST_YELLOW;
                    tmr_nx   = TMR_W'(YELLOW_CYC);
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            ST_YELLOW: begin
                if (tmr <= TMR_W'(1)) begin
                    if (emg_any) begin
`ifdef TRAFFIC_EMERGENCY_EN
                        state_nx = ST_EMG;
                        idx_nx   = emg_j;
                        tmr_nx   = '0;
`endif
                    end else if (act) begin
                        state_nx = ST_GREEN;
                        idx_nx   = idx + 2'd1;
                        tmr_nx   = TMR_W'(GREEN_CYC);
                    end else begin
                        state_nx = ST_IDLE;
                        tmr_nx   = '0;
                    end
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
`ifdef TRAFFIC_EMERGENCY_EN
            ST_EMG: begin
                // Held by its own request only; other requests wait for the yellow exit.
                if (!emg[idx]) begin
                    state_nx = ST_YELLOW;
                    tmr_nx   = TMR_W'(YELLOW_CYC);
                end
            end
`endif
            default: begin
                state_nx = ST_IDLE;
                tmr_nx   = '0;
            end
        endcase

`ifdef TRAFFIC_EMERGENCY_EN
        in_emg = (state_nx == ST_EMG);
`endif

        for (int a = 0; a < NUM_APP; a++) begin
            if (idx_nx == 2'(a)) begin
                unique case (state_nx)
                    ST_GREEN:  lights_c[a] = GREEN;
                    ST_YELLOW: lights_c[a] = YELLOW;
`ifdef TRAFFIC_EMERGENCY_EN
                    ST_EMG:    lights_c[a] = EMG_CODE;
`endif
                    default:   lights_c[a] = RED;
                endcase
            end
            if (lights_c[a] == RED && ped[a] && !in_emg) begin
                lights_c[a][WALK_BIT] = 1'b1;
            end
        end
    end

    assign out_f = lights_q[0];
    assign out_r = lights_q[1];
    assign out_b = lights_q[2];
    assign out_l = lights_q[3];

endmodule

// File: tb/tb_traffic_signal.sv
// Directed self-checking bench for traffic_signal; emergency cases follow TRAFFIC_EMERGENCY_EN.
module tb_traffic_signal;

    localparam int unsigned IMG_W = 3072;
    localparam int unsigned D_W   = 14;

    localparam logic [4:0] C_RED = 5'b00001;
    localparam logic [4:0] C_YEL = 5'b00010;
    localparam logic [4:0] C_GRN = 5'b00100;
    localparam logic [4:0] C_WLK = 5'b01001;
    localparam logic [4:0] C_EMG = 5'b10100;

    logic             clk = 1'b0;
    logic             rst;
    logic [IMG_W-1:0] img_in;
    logic             act;
    logic [3:0]       ped;
    logic [3:0]       emg;
    logic [4:0]       out_f, out_r, out_b, out_l;
    logic [IMG_W-1:0] img_out;
    logic [D_W-1:0]   density;

    int vectors     = 0;
    int miscompares = 0;

    traffic_signal #(
        .IMG_W      (IMG_W),
        .D_W        (D_W),
        .GREEN_CYC  (8),
        .YELLOW_CYC (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .img_in  (img_in),
        .act     (act),
        .ped     (ped),
        .emg     (emg),
        .out_f   (out_f),
        .out_r   (out_r),
        .out_b   (out_b),
        .out_l   (out_l),
        .img_out (img_out),
        .density (density)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] light(input int a);
        case (a)
            0:       light = out_f;
            1:       light = out_r;
            2:       light = out_b;
            default: light = out_l;
        endcase
    endfunction

    task automatic check(input string tag, input logic [IMG_W-1:0] got, input logic [IMG_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (low 64b)", tag, got[63:0], exp[63:0]);
        end
    endtask

    task automatic check_all_red(input string tag);
        check({tag, " f"}, IMG_W'(out_f), IMG_W'(C_RED));
        check({tag, " r"}, IMG_W'(out_r), IMG_W'(C_RED));
        check({tag, " b"}, IMG_W'(out_b), IMG_W'(C_RED));
        check({tag, " l"}, IMG_W'(out_l), IMG_W'(C_RED));
    endtask

    logic [IMG_W-1:0] pat;

    initial begin
        rst    = 1'b1;
        img_in = '0;
        act    = 1'b0;
        ped    = 4'b0000;
        emg    = 4'b0000;
        repeat (2) @(negedge clk);
        check_all_red("reset");
        check("reset density", IMG_W'(density), '0);
        check("reset img_out", img_out, '0);
        rst = 1'b0;

        // Density and image copy.
        pat = '0;
        for (int i = 0; i < 100; i++) pat[i*7] = 1'b1;
        img_in = pat;
        @(negedge clk);
        check("density 100", IMG_W'(density), IMG_W'(100));
        check("img_out 100", img_out, pat);
        img_in = '1;
        @(negedge clk);
        check("density all", IMG_W'(density), IMG_W'(3072));
        check("img_out all", img_out, '1);
        img_in = '0;
        @(negedge clk);
        check("density zero", IMG_W'(density), '0);
        check("img_out zero", img_out, '0);

        // Walk in IDLE.
        ped = 4'b0001;
        @(negedge clk);
        check("idle walk f", IMG_W'(out_f), IMG_W'(C_WLK));
        check("idle walk r", IMG_W'(out_r), IMG_W'(C_RED));
        ped = 4'b0000;

        // Full rotation F -> R -> B -> L -> F.
        act = 1'b1;
        for (int a = 0; a < 4; a++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                check($sformatf("seq grn a%0d c%0d", a, c), IMG_W'(light(a)), IMG_W'(C_GRN));
                check($sformatf("seq oth a%0d c%0d", a, c), IMG_W'(light((a + 1) % 4)), IMG_W'(C_RED));
            end
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                check($sformatf("seq yel a%0d c%0d", a, c), IMG_W'(light(a)), IMG_W'(C_YEL));
            end
        end
        @(negedge clk);
        check("wrap f green", IMG_W'(out_f), IMG_W'(C_GRN));
        check("wrap l red", IMG_W'(out_l), IMG_W'(C_RED));

        // Grant loss early in GREEN(F).
        @(negedge clk);
        act = 1'b0;
        @(negedge clk);
        check("loss yel1", IMG_W'(out_f), IMG_W'(C_YEL));
        @(negedge clk);
        check("loss yel2", IMG_W'(out_f), IMG_W'(C_YEL));
        @(negedge clk);
        check_all_red("loss idle");

        // Walk on red approaches only, never on the green one.
        ped = 4'b0011;
        act = 1'b1;
        @(negedge clk);
        check("green no walk f", IMG_W'(out_f), IMG_W'(C_GRN));
        check("green walk r", IMG_W'(out_r), IMG_W'(C_WLK));
        ped = 4'b0000;

`ifdef TRAFFIC_EMERGENCY_EN
        // Emergency on B during GREEN(F).
        emg = 4'b0100;
        @(negedge clk);
        check("emg f yel1", IMG_W'(out_f), IMG_W'(C_YEL));
        check("emg b red", IMG_W'(out_b), IMG_W'(C_RED));
        @(negedge clk);
        check("emg f yel2", IMG_W'(out_f), IMG_W'(C_YEL));
        @(negedge clk);
        check("emg b on", IMG_W'(out_b), IMG_W'(C_EMG));
        check("emg f red", IMG_W'(out_f), IMG_W'(C_RED));
        emg = 4'b0101;
        ped = 4'b0001;
        @(negedge clk);
        check("emg hold b", IMG_W'(out_b), IMG_W'(C_EMG));
        check("emg no walk f", IMG_W'(out_f), IMG_W'(C_RED));
        emg = 4'b0000;
        ped = 4'b0000;
        @(negedge clk);
        check("emg b yel1", IMG_W'(out_b), IMG_W'(C_YEL));
        @(negedge clk);
        check("emg b yel2", IMG_W'(out_b), IMG_W'(C_YEL));
        @(negedge clk);
        check("emg then l", IMG_W'(out_l), IMG_W'(C_GRN));
        check("emg b back red", IMG_W'(out_b), IMG_W'(C_RED));

        // Emergency on the approach currently green.
        emg = 4'b1000;
        @(negedge clk);
        check("emg same l", IMG_W'(out_l), IMG_W'(C_EMG));
        emg = 4'b0000;
        @(negedge clk);
        check("emg l yel1", IMG_W'(out_l), IMG_W'(C_YEL));
        @(negedge clk);
        check("emg l yel2", IMG_W'(out_l), IMG_W'(C_YEL));
        @(negedge clk);
        check("emg l then f", IMG_W'(out_f), IMG_W'(C_GRN));

        // Emergency from IDLE picks the lowest set bit.
        act = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_all_red("pre idle emg");
        emg = 4'b0110;
        @(negedge clk);
        check("idle emg r", IMG_W'(out_r), IMG_W'(C_EMG));
        check("idle emg b", IMG_W'(out_b), IMG_W'(C_RED));
        emg = 4'b0000;
        @(negedge clk);
        check("idle emg r yel", IMG_W'(out_r), IMG_W'(C_YEL));
        @(negedge clk);
        @(negedge clk);
        check_all_red("idle emg done");
`else
        // Emergency requests have no effect in this build.
        emg = 4'b0100;
        @(negedge clk);
        check("no emg f green", IMG_W'(out_f), IMG_W'(C_GRN));
        check("no emg b red", IMG_W'(out_b), IMG_W'(C_RED));
        emg = 4'b0000;
`endif

        // Asynchronous reset in the middle of GREEN.
        img_in = '1;
        act    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre rst green", IMG_W'(out_f), IMG_W'(C_GRN));
        check("pre rst density", IMG_W'(density), IMG_W'(3072));
        #2;
        rst = 1'b1;
        #1;
        check_all_red("mid rst");
        check("mid rst density", IMG_W'(density), '0);
        check("mid rst img_out", img_out, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst green", IMG_W'(out_f), IMG_W'(C_GRN));
        check("post rst density", IMG_W'(density), IMG_W'(3072));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
